// File: rtl/instruction_ram_loader_if.sv
// rtl/instruction_ram_loader_if.sv - load stream and fetch port bundle for the instruction RAM loader
interface instruction_ram_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  load_busy;
    logic                  load_done;
    logic                  load_error;
    logic                  fetch_enable;
    logic [ADDR_WIDTH-1:0] fetch_address;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_valid;
    logic                  fetch_error;

    // Program source / processor side
    modport master (
        output load_start, load_base, load_count, load_valid, load_data,
        output fetch_enable, fetch_address,
        input  load_ready, load_busy, load_done, load_error,
        input  fetch_data, fetch_valid, fetch_error
    );

    // Memory / loader side
    modport slave (
        input  load_start, load_base, load_count, load_valid, load_data,
        input  fetch_enable, fetch_address,
        output load_ready, load_busy, load_done, load_error,
        output fetch_data, fetch_valid, fetch_error
    );
endinterface

// File: rtl/instruction_ram_loader.sv
// rtl/instruction_ram_loader.sv - instruction memory with burst program loader and registered fetch port
module instruction_ram_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int BYPASS     = 1
) (
    input logic                    clock,
    input logic                    reset_n,
    instruction_ram_loader_if.slave bus
);
    // Index width of the implemented array; at least one bit so DEPTH=1 still slices cleanly.
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] ptr;        // one bit wider than the address so it cannot wrap to 0
    logic [ADDR_WIDTH:0] remaining;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic ptr_in_range;
    logic wr_en;
    logic fetch_in_range;
    logic bypass_hit;

    assign accept         = (state == LOAD) && bus.load_valid;
    assign ptr_in_range   = (ptr < DEPTH_W);
    assign wr_en          = accept && ptr_in_range;
    assign fetch_in_range = ({1'b0, bus.fetch_address} < DEPTH_W);
    assign bypass_hit     = wr_en && (ptr == {1'b0, bus.fetch_address});

    // Loader FSM; handshake/status outputs are registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= '0;
            remaining      <= '0;
            bus.load_ready <= 1'b0;
            bus.load_busy  <= 1'b0;
            bus.load_done  <= 1'b0;
            bus.load_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.load_done <= 1'b0;
                    if (bus.load_start) begin
                        ptr            <= {1'b0, bus.load_base};
                        remaining      <= bus.load_count;
                        bus.load_error <= 1'b0;
                        bus.load_busy  <= 1'b1;
                        if (bus.load_count == '0) begin
                            state          <= DONE;
                            bus.load_ready <= 1'b0;
                            bus.load_done  <= 1'b1;
                        end else begin
                            state          <= LOAD;
                            bus.load_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (ptr_in_range) begin
                            ptr       <= ptr + 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                                state          <= DONE;
                                bus.load_ready <= 1'b0;
                                bus.load_done  <= 1'b1;
                            end
                        end else begin
                            // Burst ran off the end of the array: abandon the rest of it.
                            bus.load_error <= 1'b1;
                            state          <= DONE;
                            bus.load_ready <= 1'b0;
                            bus.load_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.load_done <= 1'b0;
                    bus.load_busy <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    bus.load_ready <= 1'b0;
                    bus.load_busy  <= 1'b0;
                    bus.load_done  <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[ptr[MEM_AW-1:0]] <= bus.load_data;
        end
    end

    // Registered fetch with range check and optional same-cycle write bypass.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.fetch_data  <= '0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_error <= 1'b0;
        end else begin
            bus.fetch_valid <= bus.fetch_enable;
            bus.fetch_error <= 1'b0;
            if (bus.fetch_enable) begin
                if (!fetch_in_range) begin
                    bus.fetch_data  <= '0;
                    bus.fetch_error <= 1'b1;
                end else if ((BYPASS != 0) && bypass_hit) begin
                    bus.fetch_data <= bus.load_data;
                end else begin
                    bus.fetch_data <= mem[bus.fetch_address[MEM_AW-1:0]];
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_ram_loader.sv
// tb/tb_instruction_ram_loader.sv - scoreboard testbench for instruction_ram_loader
module tb_instruction_ram_loader;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    instruction_ram_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus0 ();
    instruction_ram_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus1 ();

    // dut0: full depth with bypass; dut1: half depth without bypass, same input stimulus
    instruction_ram_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1024), .BYPASS(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0)
    );
    instruction_ram_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(512), .BYPASS(0)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1)
    );

    assign bus1.load_start    = bus0.load_start;
    assign bus1.load_base     = bus0.load_base;
    assign bus1.load_count    = bus0.load_count;
    assign bus1.load_valid    = bus0.load_valid;
    assign bus1.load_data     = bus0.load_data;
    assign bus1.fetch_enable  = bus0.fetch_enable;
    assign bus1.fetch_address = bus0.fetch_address;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        care;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] burst_words [8];

    function automatic exp_t mk(input logic [31:0] d, input logic e, input logic c);
        exp_t r;
        r.data = d;
        r.err  = e;
        r.care = c;
        return r;
    endfunction

    // Fetch scoreboard: every valid fetch result pops one expectation per DUT
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus0.fetch_valid === 1'b1) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL fetch0_unexpected got data=%h err=%b required no fetch", bus0.fetch_data, bus0.fetch_error);
                end else begin
                    e = q0.pop_front();
                    if (bus0.fetch_error !== e.err || (e.care && bus0.fetch_data !== e.data)) begin
                        failures++;
                        $display("FAIL fetch0 got data=%h err=%b required data=%h err=%b", bus0.fetch_data, bus0.fetch_error, e.data, e.err);
                    end
                end
            end
            if (bus1.fetch_valid === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL fetch1_unexpected got data=%h err=%b required no fetch", bus1.fetch_data, bus1.fetch_error);
                end else begin
                    e = q1.pop_front();
                    if (bus1.fetch_error !== e.err || (e.care && bus1.fetch_data !== e.data)) begin
                        failures++;
                        $display("FAIL fetch1 got data=%h err=%b required data=%h err=%b", bus1.fetch_data, bus1.fetch_error, e.data, e.err);
                    end
                end
            end
        end
    end

    // All driving tasks start and end at 1 time unit after a rising edge.
    task automatic start_load(input logic [9:0] base, input logic [10:0] count);
        bus0.load_start = 1'b1;
        bus0.load_base  = base;
        bus0.load_count = count;
        @(posedge clock); #1;
        bus0.load_start = 1'b0;
    endtask

    task automatic run_burst(input logic [9:0] base, input logic [10:0] count, input int nwords, input bit gaps,
                             output int n_acc, output int n_done, output bit lag_ok,
                             output bit ready_seen, output bit busy_start);
        bit acc;
        n_acc = 0; n_done = 0; lag_ok = 1'b0; ready_seen = 1'b0;
        start_load(base, count);
        busy_start = bus0.load_busy;
        if (bus0.load_done === 1'b1) begin
            n_done++;
            lag_ok = 1'b1;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus0.load_ready === 1'b1) ready_seen = 1'b1;
            bus0.load_valid = (n_acc < nwords) && (!gaps || cyc[0]);
            bus0.load_data  = burst_words[n_acc % 8];
            acc = bus0.load_valid && (bus0.load_ready === 1'b1);
            @(posedge clock); #1;
            if (acc) n_acc++;
            if (bus0.load_done === 1'b1) begin
                n_done++;
                lag_ok = acc;
            end
        end
        bus0.load_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [9:0] addr, input exp_t e0, input exp_t e1);
        bus0.fetch_enable  = 1'b1;
        bus0.fetch_address = addr;
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({bus0.load_ready, bus0.load_busy, bus0.load_done, bus0.load_error, bus0.fetch_valid, bus0.fetch_error, bus0.fetch_data} !== 38'd0) begin
            failures++;
            $display("FAIL reset0 got %b required 0", {bus0.load_ready, bus0.load_busy, bus0.load_done, bus0.load_error, bus0.fetch_valid, bus0.fetch_error, bus0.fetch_data});
        end
        checks++;
        if ({bus1.load_ready, bus1.load_busy, bus1.load_done, bus1.load_error, bus1.fetch_valid, bus1.fetch_error, bus1.fetch_data} !== 38'd0) begin
            failures++;
            $display("FAIL reset1 got %b required 0", {bus1.load_ready, bus1.load_busy, bus1.load_done, bus1.load_error, bus1.fetch_valid, bus1.fetch_error, bus1.fetch_data});
        end
    endtask

    task automatic test_reset_mid_burst;
        int dones;
        start_load(10'h100, 11'd5);
        for (int i = 0; i < 3; i++) begin
            bus0.load_valid = 1'b1;
            bus0.load_data  = 32'hC0DE0000 + i;
            @(posedge clock); #1;
        end
        bus0.load_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus0.load_ready, bus0.load_busy, bus0.load_done, bus0.load_error, bus0.fetch_valid, bus0.fetch_error} !== 6'd0) begin
            failures++;
            $display("FAIL midreset0 got %b required 000000", {bus0.load_ready, bus0.load_busy, bus0.load_done, bus0.load_error, bus0.fetch_valid, bus0.fetch_error});
        end
        checks++;
        if ({bus1.load_ready, bus1.load_busy, bus1.load_done, bus1.load_error, bus1.fetch_valid, bus1.fetch_error} !== 6'd0) begin
            failures++;
            $display("FAIL midreset1 got %b required 000000", {bus1.load_ready, bus1.load_busy, bus1.load_done, bus1.load_error, bus1.fetch_valid, bus1.fetch_error});
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (bus0.load_done === 1'b1 || bus0.load_busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL midreset_nodone got %0d done/busy cycles required 0", dones);
        end
        for (int i = 0; i < 3; i++) begin
            do_fetch(10'h100 + 10'(i), mk(32'hC0DE0000 + i, 1'b0, 1'b1), mk(32'hC0DE0000 + i, 1'b0, 1'b1));
        end
        bus0.fetch_enable = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_burst;
        int n_acc, n_done;
        bit lag_ok, ready_seen, busy_start;
        for (int i = 0; i < 4; i++) burst_words[i] = 32'hA0A0_0000 + i;
        run_burst(10'h010, 11'd4, 4, 1'b1, n_acc, n_done, lag_ok, ready_seen, busy_start);
        checks++;
        if (n_acc !== 4 || n_done !== 1 || !lag_ok || !busy_start) begin
            failures++;
            $display("FAIL burst got acc=%0d done=%0d lag=%b busy=%b required acc=4 done=1 lag=1 busy=1", n_acc, n_done, lag_ok, busy_start);
        end
        checks++;
        if (bus0.load_busy !== 1'b0 || bus0.load_error !== 1'b0) begin
            failures++;
            $display("FAIL burst_idle got busy=%b err=%b required 0 0", bus0.load_busy, bus0.load_error);
        end
        for (int i = 0; i < 4; i++) begin
            do_fetch(10'h010 + 10'(i), mk(32'hA0A0_0000 + i, 1'b0, 1'b1), mk(32'hA0A0_0000 + i, 1'b0, 1'b1));
        end
        bus0.fetch_enable = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (bus0.fetch_valid !== 1'b0 || bus0.fetch_data !== 32'hA0A0_0003) begin
            failures++;
            $display("FAIL fetch_hold got valid=%b data=%h required 0 a0a00003", bus0.fetch_valid, bus0.fetch_data);
        end
    endtask

    task automatic test_overflow;
        int n_acc, n_done;
        bit lag_ok, ready_seen, busy_start;
        burst_words[0] = 32'h5A5A0000;
        run_burst(10'h000, 11'd1, 1, 1'b0, n_acc, n_done, lag_ok, ready_seen, busy_start);
        for (int i = 0; i < 4; i++) burst_words[i] = 32'hB0B0_0000 + i;
        run_burst(10'h3FE, 11'd4, 4, 1'b0, n_acc, n_done, lag_ok, ready_seen, busy_start);
        checks++;
        if (n_acc !== 3 || n_done !== 1 || !lag_ok) begin
            failures++;
            $display("FAIL overflow got acc=%0d done=%0d lag=%b required acc=3 done=1 lag=1", n_acc, n_done, lag_ok);
        end
        checks++;
        if (bus0.load_error !== 1'b1 || bus1.load_error !== 1'b1) begin
            failures++;
            $display("FAIL overflow_err got %b%b required 11", bus0.load_error, bus1.load_error);
        end
        do_fetch(10'h3FE, mk(32'hB0B0_0000, 1'b0, 1'b1), mk(32'h0, 1'b1, 1'b1));
        do_fetch(10'h3FF, mk(32'hB0B0_0001, 1'b0, 1'b1), mk(32'h0, 1'b1, 1'b1));
        do_fetch(10'h000, mk(32'h5A5A0000, 1'b0, 1'b1), mk(32'h5A5A0000, 1'b0, 1'b1));
        bus0.fetch_enable = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_zero_count;
        int n_acc, n_done;
        bit lag_ok, ready_seen, busy_start;
        burst_words[0] = 32'hFFFF_FFFF;
        run_burst(10'h000, 11'd0, 0, 1'b0, n_acc, n_done, lag_ok, ready_seen, busy_start);
        checks++;
        if (n_done !== 1 || !lag_ok || ready_seen || n_acc !== 0) begin
            failures++;
            $display("FAIL zero_count got done=%0d lag=%b ready=%b acc=%0d required 1 1 0 0", n_done, lag_ok, ready_seen, n_acc);
        end
        checks++;
        if (bus0.load_error !== 1'b0 || bus1.load_error !== 1'b0) begin
            failures++;
            $display("FAIL error_clear got %b%b required 00", bus0.load_error, bus1.load_error);
        end
        do_fetch(10'h000, mk(32'h5A5A0000, 1'b0, 1'b1), mk(32'h5A5A0000, 1'b0, 1'b1));
        bus0.fetch_enable = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_collision;
        int n_acc, n_done;
        bit lag_ok, ready_seen, busy_start;
        burst_words[0] = 32'h11111111;
        run_burst(10'h020, 11'd1, 1, 1'b0, n_acc, n_done, lag_ok, ready_seen, busy_start);
        start_load(10'h020, 11'd1);
        bus0.load_valid    = 1'b1;
        bus0.load_data     = 32'hDEADBEEF;
        bus0.fetch_enable  = 1'b1;
        bus0.fetch_address = 10'h020;
        q0.push_back(mk(32'hDEADBEEF, 1'b0, 1'b1));
        q1.push_back(mk(32'h11111111, 1'b0, 1'b1));
        @(posedge clock); #1;
        bus0.load_valid   = 1'b0;
        bus0.fetch_enable = 1'b0;
        checks++;
        if (bus0.load_done !== 1'b1 || bus1.load_done !== 1'b1) begin
            failures++;
            $display("FAIL collision_done got %b%b required 11", bus0.load_done, bus1.load_done);
        end
        @(posedge clock); #1;
        do_fetch(10'h020, mk(32'hDEADBEEF, 1'b0, 1'b1), mk(32'hDEADBEEF, 1'b0, 1'b1));
        bus0.fetch_enable = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_range;
        do_fetch(10'h200, mk(32'h0, 1'b0, 1'b0), mk(32'h0, 1'b1, 1'b1));
        do_fetch(10'h1FF, mk(32'h0, 1'b0, 1'b0), mk(32'h0, 1'b0, 1'b0));
        bus0.fetch_enable = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (bus1.fetch_error !== 1'b0 || bus1.fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL range_idle got err=%b valid=%b required 0 0", bus1.fetch_error, bus1.fetch_valid);
        end
    endtask

    initial begin
        bus0.load_start    = 1'b0;
        bus0.load_base     = '0;
        bus0.load_count    = '0;
        bus0.load_valid    = 1'b0;
        bus0.load_data     = '0;
        bus0.fetch_enable  = 1'b0;
        bus0.fetch_address = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        test_reset;
        test_reset_mid_burst;
        test_burst;
        test_overflow;
        test_zero_count;
        test_collision;
        test_range;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (q0.size() !== 0 || q1.size() !== 0) begin
            failures++;
            $display("FAIL drain got pending=%0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
